trap_priority_controller: RTL and testbench
===========================================

Name: trap_priority_controller

Overview:
- Collects synchronous exception requests, trap-instruction (Ticc) requests and external interrupt requests.
- Selects the highest-priority request using SPARC V8 ordering and produces the 7-bit Trap_Type code.
- Pulses TBR_tt_Ld so the Trap Base Register captures tt, then handshakes with the control unit until trap entry completes.
- Sits directly upstream of the Trap Base Register and drives its Trap_Type and TBR_tt_Ld inputs.

Parameters:
- TIMEOUT, 16: maximum cycles in WAIT_DONE without Trap_Done before entering error mode.
- TICC_BASE, 7'h40: base code OR-ed with Ticc_Num[5:0] for trap instructions.
- IRQ_BASE, 7'h10: base code added to the interrupt level.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-low reset.
- Exc_Req  input  8  level exception requests; bit0 is highest priority (map in Behaviour).
- Ticc_Req  input  1  trap instruction executed with condition true.
- Ticc_Num  input  7  software trap number; only bits [5:0] are used.
- Irq_Level  input  4  external interrupt level; 0 means none.
- ET  input  1  PSR enable-traps bit.
- PIL  input  4  PSR processor interrupt level.
- Trap_Done  input  1  control unit finished trap entry (PC/nPC saved, CWP decremented).
- Trap_Type  output  7  selected tt code, held stable from LOAD through WAIT_DONE.
- TBR_tt_Ld  output  1  one-cycle load strobe to the Trap Base Register.
- Flush  output  1  one-cycle pipeline flush, coincident with TBR_tt_Ld.
- Trap_Busy  output  1  high in LOAD and WAIT_DONE.
- Error_Mode  output  1  sticky; high in ERROR.

Behaviour:
- Exc_Req map, in priority order:
  - bit0 instruction_access_exception, 7'h01
  - bit1 privileged_instruction, 7'h03
  - bit2 illegal_instruction, 7'h02
  - bit3 fp_disabled, 7'h04
  - bit4 window_overflow, 7'h05
  - bit5 window_underflow, 7'h06
  - bit6 mem_address_not_aligned, 7'h07
  - bit7 data_access_exception, 7'h09
- Ticc ranks below all Exc_Req bits; tt = TICC_BASE | Ticc_Num[5:0].
- Interrupts rank lowest; tt = IRQ_BASE + Irq_Level.
- An interrupt is valid only when ET=1, Irq_Level!=0, and either Irq_Level==15 or Irq_Level>PIL.
- Reset (async, low): state IDLE, Trap_Type=0, TBR_tt_Ld=0, Flush=0, Trap_Busy=0, Error_Mode=0, timeout counter=0. Reset asserted mid-operation aborts immediately with the same values.
- State machine:
  - IDLE: requests are sampled only in this state. If any Exc_Req or Ticc_Req is set while ET=0, go to ERROR. If the winning request is valid and ET=1, register Trap_Type and go to LOAD. Otherwise stay in IDLE.
  - LOAD (exactly 1 cycle): TBR_tt_Ld=1, Flush=1, Trap_Busy=1. Clear the counter, then go to WAIT_DONE.
  - WAIT_DONE: Trap_Busy=1 and the counter increments each cycle. Trap_Done=1 returns to IDLE on the next edge. If the counter reaches TIMEOUT-1 without Trap_Done, go to ERROR. If Trap_Done and the timeout occur on the same edge, Trap_Done wins.
  - ERROR: Error_Mode=1 and all other strobes are 0. Only Reset exits this state.
- Latency: a request seen in IDLE at edge N gives TBR_tt_Ld high during cycle N+1. The Trap Base Register captures tt on the falling edge inside that cycle.
- Requests arriving during LOAD or WAIT_DONE are ignored; sources must hold them until the trap is serviced. After Trap_Done, the first IDLE cycle re-arbitrates.
- Trap_Type is never modified outside IDLE→LOAD. A Trap_Done received in IDLE or LOAD is ignored.
- Simultaneous requests: exactly one winner by fixed priority. Losing requests are re-evaluated only after return to IDLE.

Test Plan:
- Reset low mid-WAIT_DONE → next cycle IDLE, Trap_Busy=0, Trap_Type=0; release reset, idle with no requests → all outputs remain 0.
- ET=1, Exc_Req=8'b0000_0100 at edge N → cycle N+1: Trap_Type=7'h02, TBR_tt_Ld=1, Flush=1; Trap_Done after 3 cycles → IDLE.
- ET=1, Exc_Req=8'b1001_0000 with Ticc_Req=1 and Irq_Level=15 → Trap_Type=7'h05; hold the window_overflow request after Trap_Done while removing Exc_Req bit7 → second trap Trap_Type=7'h05 again. With only Ticc remaining and Ticc_Num=7'h05 → Trap_Type=7'h45.
- ET=1, PIL=5: Irq_Level=5 → no trap; Irq_Level=6 → Trap_Type=7'h16; PIL=15 with Irq_Level=15 → Trap_Type=7'h1F.
- ET=0 with Irq_Level=9 → ignored. ET=0 with Exc_Req bit6 → ERROR, Error_Mode=1 sticky until Reset.
- Enter WAIT_DONE and withhold Trap_Done → after 16 cycles Error_Mode=1. Repeat with Trap_Done on the timeout edge → IDLE, Error_Mode=0.

Source files
------------

// File: rtl/trap_priority_controller.sv
// trap_priority_controller
// Arbitrates synchronous exceptions, Ticc trap instructions and external
// interrupts using SPARC V8 priority. The winning 7-bit tt code is loaded
// into the Trap Base Register, then the block waits for the control unit
// to finish trap entry. If trap entry is never acknowledged, or a
// synchronous trap occurs with traps disabled, the block enters a sticky
// error state that only reset can clear.
module trap_priority_controller #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [6:0]  TICC_BASE = 7'h40,
  parameter logic [6:0]  IRQ_BASE  = 7'h10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Exc_Req,
  input  logic       Ticc_Req,
  input  logic [6:0] Ticc_Num,
  input  logic [3:0] Irq_Level,
  input  logic       ET,
  input  logic [3:0] PIL,
  input  logic       Trap_Done,
  output logic [6:0] Trap_Type,
  output logic       TBR_tt_Ld,
  output logic       Flush,
  output logic       Trap_Busy,
  output logic       Error_Mode
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_ERROR = 2'b11
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [6:0]       trap_type_r;
  logic             tbr_ld_r;
  logic             flush_r;
  logic             busy_r;
  logic             err_r;

  logic [6:0] exc_tt_s;
  logic [6:0] tt_s;
  logic       sync_req_s;
  logic       irq_valid_s;
  logic       trap_valid_s;

  // Only the low six bits of the software trap number form the tt code.
  logic       unused_s;
  assign unused_s = Ticc_Num[6];

  // Fixed-priority encode of the exception vector: bit0 wins.
  always_comb begin
    exc_tt_s = 7'h00;
    casez (Exc_Req)
      8'b???????1: exc_tt_s = 7'h01;
      8'b??????10: exc_tt_s = 7'h03;
      8'b?????100: exc_tt_s = 7'h02;
      8'b????1000: exc_tt_s = 7'h04;
      8'b???10000: exc_tt_s = 7'h05;
      8'b??100000: exc_tt_s = 7'h06;
      8'b?1000000: exc_tt_s = 7'h07;
      8'b10000000: exc_tt_s = 7'h09;
      default:     exc_tt_s = 7'h00;
    endcase
  end

  // Qualify the interrupt and pick the overall winner: exceptions, then Ticc, then IRQ.
  always_comb begin
    sync_req_s  = (|Exc_Req) | Ticc_Req;
    irq_valid_s = ET && (Irq_Level != 4'd0) &&
                  ((Irq_Level == 4'd15) || (Irq_Level > PIL));
    tt_s        = 7'h00;
    if (|Exc_Req) begin
      tt_s = exc_tt_s;
    end else if (Ticc_Req) begin
      tt_s = TICC_BASE | {1'b0, Ticc_Num[5:0]};
    end else if (irq_valid_s) begin
      tt_s = IRQ_BASE + {3'b000, Irq_Level};
    end else begin
      tt_s = 7'h00;
    end
    trap_valid_s = sync_req_s | irq_valid_s;
  end

  // Trap sequencing FSM with registered strobes, tt code and timeout counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      trap_type_r <= 7'h00;
      tbr_ld_r    <= 1'b0;
      flush_r     <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tbr_ld_r <= 1'b0;
          flush_r  <= 1'b0;
          if (sync_req_s && !ET) begin
            // A synchronous trap with traps disabled cannot be taken.
            state_r <= ST_ERROR;
            busy_r  <= 1'b0;
            err_r   <= 1'b1;
          end else if (trap_valid_s && ET) begin
            state_r     <= ST_LOAD;
            trap_type_r <= tt_s;
            tbr_ld_r    <= 1'b1;
            flush_r     <= 1'b1;
            busy_r      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          state_r  <= ST_WAIT;
          cnt_r    <= '0;
          tbr_ld_r <= 1'b0;
          flush_r  <= 1'b0;
          busy_r   <= 1'b1;
        end
        ST_WAIT: begin
          tbr_ld_r <= 1'b0;
          flush_r  <= 1'b0;
          if (Trap_Done) begin
            // Acknowledge beats a timeout landing on the same edge.
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= ST_ERROR;
            busy_r  <= 1'b0;
            err_r   <= 1'b1;
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            busy_r <= 1'b1;
          end
        end
        ST_ERROR: begin
          state_r  <= ST_ERROR;
          tbr_ld_r <= 1'b0;
          flush_r  <= 1'b0;
          busy_r   <= 1'b0;
          err_r    <= 1'b1;
        end
        default: begin
          // Unreachable encoding: fail safe into the sticky error state.
          state_r  <= ST_ERROR;
          tbr_ld_r <= 1'b0;
          flush_r  <= 1'b0;
          busy_r   <= 1'b0;
          err_r    <= 1'b1;
        end
      endcase
    end
  end

  assign Trap_Type  = trap_type_r;
  assign TBR_tt_Ld  = tbr_ld_r;
  assign Flush      = flush_r;
  assign Trap_Busy  = busy_r;
  assign Error_Mode = err_r;

endmodule

// File: tb/tb_trap_priority_controller.sv
// Scoreboard bench for trap_priority_controller: the stimulus thread pushes
// expected tt codes from a behavioural priority model; a monitor pops one
// on every TBR_tt_Ld strobe and compares.
module tb_trap_priority_controller;

  logic       Clock;
  logic       Reset;
  logic [7:0] Exc_Req;
  logic       Ticc_Req;
  logic [6:0] Ticc_Num;
  logic [3:0] Irq_Level;
  logic       ET;
  logic [3:0] PIL;
  logic       Trap_Done;
  logic [6:0] Trap_Type;
  logic       TBR_tt_Ld;
  logic       Flush;
  logic       Trap_Busy;
  logic       Error_Mode;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];

  trap_priority_controller dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Exc_Req    (Exc_Req),
    .Ticc_Req   (Ticc_Req),
    .Ticc_Num   (Ticc_Num),
    .Irq_Level  (Irq_Level),
    .ET         (ET),
    .PIL        (PIL),
    .Trap_Done  (Trap_Done),
    .Trap_Type  (Trap_Type),
    .TBR_tt_Ld  (TBR_tt_Ld),
    .Flush      (Flush),
    .Trap_Busy  (Trap_Busy),
    .Error_Mode (Error_Mode)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference: priority from the table, then Ticc, then qualified interrupt.
  // kind: 0 = no trap, 1 = trap with tt, 2 = error (sync trap with ET=0).
  function automatic void model(input logic [7:0] exc, input logic ticc,
                                input logic [6:0] num, input logic [3:0] irq,
                                input logic et, input logic [3:0] pil,
                                output int kind, output int tt);
    int codes [8];
    codes = '{1, 3, 2, 4, 5, 6, 7, 9};
    kind = 0;
    tt   = 0;
    if ((exc != 0 || ticc) && !et) begin
      kind = 2;
      return;
    end
    for (int i = 0; i < 8; i++)
      if (exc[i] && kind == 0) begin
        kind = 1;
        tt   = codes[i];
      end
    if (kind == 0 && ticc) begin
      kind = 1;
      tt   = 64 + (int'(num) % 64);
    end
    if (kind == 0 && et && irq != 0 && (irq == 15 || int'(irq) > int'(pil))) begin
      kind = 1;
      tt   = 16 + int'(irq);
    end
  endfunction

  task automatic drive(input logic [7:0] exc, input logic ticc, input logic [6:0] num,
                       input logic [3:0] irq, input logic et, input logic [3:0] pil);
    Exc_Req   = exc;
    Ticc_Req  = ticc;
    Ticc_Num  = num;
    Irq_Level = irq;
    ET        = et;
    PIL       = pil;
  endtask

  // Called at posedge+1 with requests applied; load is due on the 2nd negedge.
  task automatic expect_trap(input string name, input logic [6:0] tt);
    int k;
    k = 0;
    exp_q.push_back(tt);
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clock);
      if (TBR_tt_Ld === 1'b1) begin
        k = i;
        break;
      end
    end
    if (k == 0) void'(exp_q.pop_back());
    check({name, "_latency"}, k, 2);
  endtask

  // From the load cycle: spend d cycles in WAIT_DONE, pulse Trap_Done and apply next requests.
  task automatic finish_trap(input int d, input logic [7:0] exc, input logic ticc,
                             input logic [6:0] num, input logic [3:0] irq);
    @(posedge Clock); #1;
    repeat (d) begin @(posedge Clock); #1; end
    Trap_Done = 1'b1;
    Exc_Req   = exc;
    Ticc_Req  = ticc;
    Ticc_Num  = num;
    Irq_Level = irq;
    @(posedge Clock); #1;
    Trap_Done = 1'b0;
    check("busy_after_done", int'(Trap_Busy), 0);
  endtask

  task automatic check_quiet(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      if (TBR_tt_Ld !== 1'b0 || Trap_Busy !== 1'b0) seen++;
    end
    check(name, seen, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    drive(8'h00, 1'b0, 7'h00, 4'h0, 1'b0, 4'h0);
    Trap_Done = 1'b0;
    #1;
    check("rst_err", int'(Error_Mode), 0);
    check("rst_busy", int'(Trap_Busy), 0);
    @(posedge Clock); #1;
    Reset = 1'b1;
  endtask

  // Monitor: pop an expectation on every load strobe; Flush must track the strobe.
  initial begin : monitor
    logic [6:0] want;
    forever begin
      @(negedge Clock);
      if (Reset === 1'b1) begin
        total++;
        if (Flush !== TBR_tt_Ld) begin
          bad++;
          $display("FAIL flush_vs_ld flush=%b ld=%b", Flush, TBR_tt_Ld);
        end
        if (TBR_tt_Ld === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_load got tt=%h want none", Trap_Type);
          end else begin
            want = exp_q.pop_front();
            if (Trap_Type !== want || Trap_Busy !== 1'b1) begin
              bad++;
              $display("FAIL load_tt got tt=%h busy=%b want tt=%h busy=1",
                       Trap_Type, Trap_Busy, want);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int kind;
    int tt;
    int k;
    int drops;
    logic [7:0] exc_v;
    logic       ticc_v;
    logic [6:0] num_v;
    logic [3:0] irq_v;
    logic [3:0] pil_v;
    logic       et_v;

    Reset     = 1'b0;
    Trap_Done = 1'b0;
    drive(8'h00, 1'b0, 7'h00, 4'h0, 1'b0, 4'h0);
    repeat (2) @(posedge Clock);
    #1;
    check("reset_tt", int'(Trap_Type), 0);
    check("reset_ld", int'(TBR_tt_Ld), 0);
    check("reset_flush", int'(Flush), 0);
    check("reset_busy", int'(Trap_Busy), 0);
    check("reset_err", int'(Error_Mode), 0);
    Reset = 1'b1;
    @(posedge Clock); #1;

    // Single illegal_instruction trap.
    drive(8'b0000_0100, 1'b0, 7'h00, 4'h0, 1'b1, 4'h0);
    expect_trap("exc_ill", 7'h02);
    finish_trap(2, 8'h00, 1'b0, 7'h00, 4'h0);

    // Reset in the middle of WAIT_DONE aborts everything.
    drive(8'h01, 1'b0, 7'h00, 4'h0, 1'b1, 4'h0);
    expect_trap("exc_iae", 7'h01);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    drive(8'h00, 1'b0, 7'h00, 4'h0, 1'b1, 4'h0);
    @(negedge Clock);
    check("midrst_busy", int'(Trap_Busy), 0);
    check("midrst_tt", int'(Trap_Type), 0);
    check("midrst_err", int'(Error_Mode), 0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    check_quiet("idle_after_reset", 4);
    check("idle_tt", int'(Trap_Type), 0);
    @(posedge Clock); #1;

    // Simultaneous requests, then re-arbitration of the held losers.
    drive(8'b1001_0000, 1'b1, 7'h05, 4'hF, 1'b1, 4'h0);
    expect_trap("prio_wo", 7'h05);
    finish_trap(1, 8'b0001_0000, 1'b1, 7'h05, 4'hF);
    expect_trap("prio_wo_again", 7'h05);
    finish_trap(1, 8'h00, 1'b1, 7'h05, 4'hF);
    expect_trap("ticc_45", 7'h45);
    finish_trap(1, 8'h00, 1'b0, 7'h00, 4'h0);

    // Interrupt level qualification against PIL.
    drive(8'h00, 1'b0, 7'h00, 4'h5, 1'b1, 4'h5);
    check_quiet("irq_eq_pil", 4);
    @(posedge Clock); #1;
    drive(8'h00, 1'b0, 7'h00, 4'h6, 1'b1, 4'h5);
    expect_trap("irq6", 7'h16);
    finish_trap(0, 8'h00, 1'b0, 7'h00, 4'h0);
    drive(8'h00, 1'b0, 7'h00, 4'hF, 1'b1, 4'hF);
    expect_trap("irq15_nmi", 7'h1F);
    finish_trap(0, 8'h00, 1'b0, 7'h00, 4'h0);

    // Traps disabled: interrupt ignored, synchronous exception is fatal.
    drive(8'h00, 1'b0, 7'h00, 4'h9, 1'b0, 4'h0);
    check_quiet("et0_irq", 4);
    @(posedge Clock); #1;
    drive(8'b0100_0000, 1'b0, 7'h00, 4'h0, 1'b0, 4'h0);
    @(negedge Clock);
    @(negedge Clock);
    check("et0_exc_err", int'(Error_Mode), 1);
    drive(8'h01, 1'b1, 7'h01, 4'hF, 1'b1, 4'h0);
    check_quiet("err_no_trap", 5);
    check("err_sticky", int'(Error_Mode), 1);
    @(posedge Clock); #1;
    do_reset();

    // Trap_Done withheld: error after TIMEOUT cycles in WAIT_DONE.
    drive(8'h08, 1'b0, 7'h00, 4'h0, 1'b1, 4'h0);
    expect_trap("fp_dis", 7'h04);
    drive(8'h00, 1'b0, 7'h00, 4'h0, 1'b1, 4'h0);
    k = 0;
    drops = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clock);
      if (Error_Mode === 1'b1) begin
        k = i;
        break;
      end
      if (Trap_Busy !== 1'b1) drops++;
    end
    check("timeout_cycles", k, 17);
    check("timeout_busy_held", drops, 0);
    check("timeout_busy_off", int'(Trap_Busy), 0);
    @(posedge Clock); #1;
    do_reset();

    // Trap_Done on the timeout edge wins.
    drive(8'h08, 1'b0, 7'h00, 4'h0, 1'b1, 4'h0);
    expect_trap("fp_dis2", 7'h04);
    drive(8'h00, 1'b0, 7'h00, 4'h0, 1'b1, 4'h0);
    repeat (16) @(posedge Clock);
    #1;
    Trap_Done = 1'b1;
    @(posedge Clock); #1;
    Trap_Done = 1'b0;
    check("done_at_timeout_err", int'(Error_Mode), 0);
    check("done_at_timeout_busy", int'(Trap_Busy), 0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      et_v   = ($urandom_range(0, 7) != 0);
      exc_v  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ticc_v = 1'($urandom_range(0, 1));
      num_v  = 7'($urandom);
      irq_v  = 4'($urandom);
      pil_v  = 4'($urandom);
      if (!et_v) begin
        exc_v  = 8'h00;
        ticc_v = 1'b0;
      end
      drive(exc_v, ticc_v, num_v, irq_v, et_v, pil_v);
      model(exc_v, ticc_v, num_v, irq_v, et_v, pil_v, kind, tt);
      if (kind == 1) begin
        expect_trap("rnd_trap", 7'(tt));
        finish_trap(int'($urandom_range(0, 5)), 8'h00, 1'b0, 7'h00, 4'h0);
      end else begin
        check_quiet("rnd_quiet", 3);
        drive(8'h00, 1'b0, 7'h00, 4'h0, 1'b1, 4'h0);
        @(posedge Clock); #1;
      end
    end

    repeat (3) @(negedge Clock);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
